// File: rtl/dmem_responder.sv
// Data-memory responder: byte-addressed word memory behind a fixed-latency
// pipeline and a credit-limited in-order response FIFO.
module dmem_responder #(
  parameter int N_BITS      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1,
  parameter int RSP_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_val,
  output logic              req_rdy,
  input  logic              req_wen,
  input  logic [N_BITS-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [N_BITS-1:0] req_wdata,
  output logic              rsp_val,
  input  logic              rsp_rdy,
  output logic [N_BITS-1:0] rsp_data,
  output logic              rsp_is_wr,
  output logic              rsp_err
);
  // Handshakes: a request transfers on a rising edge with req_val && req_rdy;
  // a response transfers with rsp_val && rsp_rdy, and rsp_* hold while stalled.

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + LATENCY + 1);

  logic [N_BITS-1:0] mem [DEPTH_WORDS];

  logic              fire;
  logic              misaligned;
  logic              bad_size;
  logic              out_of_range;
  logic              err;
  logic [IDX_W-1:0]  word_idx;
  logic [N_BITS-1:0] rd_word;
  logic [N_BITS-1:0] shifted;
  logic [N_BITS-1:0] load_data;
  logic [N_BITS-1:0] wr_lanes;
  logic [3:0]        wr_be;

  assign fire     = req_val && req_rdy;
  assign word_idx = req_addr[IDX_W+1:2];
  assign rd_word  = mem[word_idx];
  assign shifted  = rd_word >> {req_addr[1:0], 3'b000};

  always_comb begin
    misaligned   = (req_size == 2'd1 && req_addr[0]) ||
                   (req_size == 2'd2 && req_addr[1:0] != 2'b00);
    bad_size     = (req_size == 2'd3);
    out_of_range = |req_addr[N_BITS-1:IDX_W+2];
    err          = misaligned || bad_size || out_of_range;
  end

  always_comb begin
    load_data = shifted;
    case (req_size)
      2'd0: load_data = req_unsigned ? {24'd0, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
      2'd1: load_data = req_unsigned ? {16'd0, shifted[15:0]}
                                     : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  // Narrow stores replicate their data so every enabled lane sees the right bytes.
  always_comb begin
    wr_lanes = req_wdata;
    wr_be    = 4'b1111;
    case (req_size)
      2'd0: begin
        wr_lanes = {4{req_wdata[7:0]}};
        wr_be    = 4'b0001 << req_addr[1:0];
      end
      2'd1: begin
        wr_lanes = {2{req_wdata[15:0]}};
        wr_be    = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wr_lanes = req_wdata;
        wr_be    = 4'b1111;
      end
    endcase
  end

  // Memory is deliberately outside reset so committed stores survive it.
  always_ff @(posedge clk) begin
    if (fire && req_wen && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[word_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
      end
    end
  end

  logic              pipe_val  [LATENCY];
  logic [N_BITS-1:0] pipe_data [LATENCY];
  logic              pipe_wr   [LATENCY];
  logic              pipe_err  [LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) pipe_val[i] <= 1'b0;
    end else begin
      pipe_val[0] <= fire;
      if (fire) begin
        pipe_data[0] <= (err || req_wen) ? '0 : load_data;
        pipe_wr[0]   <= req_wen;
        pipe_err[0]  <= err;
      end
      for (int i = 1; i < LATENCY; i++) begin
        pipe_val[i]  <= pipe_val[i-1];
        pipe_data[i] <= pipe_data[i-1];
        pipe_wr[i]   <= pipe_wr[i-1];
        pipe_err[i]  <= pipe_err[i-1];
      end
    end
  end

  logic [N_BITS-1:0] fifo_data [RSP_DEPTH];
  logic              fifo_wr   [RSP_DEPTH];
  logic              fifo_err  [RSP_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  inflight;
  logic              push;
  logic              pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign push = pipe_val[LATENCY-1];
  assign pop  = rsp_val && rsp_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= pipe_data[LATENCY-1];
        fifo_wr[wr_ptr]   <= pipe_wr[LATENCY-1];
        fifo_err[wr_ptr]  <= pipe_err[LATENCY-1];
        wr_ptr            <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Credit is built only from registered state, so a pop frees it one cycle later.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) inflight = inflight + CNT_W'(pipe_val[i]);
  end

  assign req_rdy   = !rst && ((inflight + fifo_count) < CNT_W'(RSP_DEPTH));
  assign rsp_val   = (fifo_count != '0);
  assign rsp_data  = rsp_val ? fifo_data[rd_ptr] : '0;
  assign rsp_is_wr = rsp_val ? fifo_wr[rd_ptr]   : 1'b0;
  assign rsp_err   = rsp_val ? fifo_err[rd_ptr]  : 1'b0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed feature tasks plus a random load/store mix,
// with responses checked in order against an expected queue.
module tb_dmem_responder;
  localparam int N_BITS      = 32;
  localparam int DEPTH_WORDS = 1024;
  localparam int LATENCY     = 1;
  localparam int RSP_DEPTH   = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_val = 1'b0;
  logic              req_rdy;
  logic              req_wen = 1'b0;
  logic [N_BITS-1:0] req_addr = '0;
  logic [1:0]        req_size = 2'd0;
  logic              req_unsigned = 1'b0;
  logic [N_BITS-1:0] req_wdata = '0;
  logic              rsp_val;
  logic              rsp_rdy = 1'b1;
  logic [N_BITS-1:0] rsp_data;
  logic              rsp_is_wr;
  logic              rsp_err;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Expected response: {is_wr, err, data}.
  logic [33:0] exp_q[$];
  logic [31:0] model_mem [DEPTH_WORDS];

  dmem_responder #(
    .N_BITS(N_BITS), .DEPTH_WORDS(DEPTH_WORDS), .LATENCY(LATENCY), .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .req_val(req_val), .req_rdy(req_rdy), .req_wen(req_wen),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .rsp_val(rsp_val), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data),
    .rsp_is_wr(rsp_is_wr), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Response scoreboard: each accepted response is compared with the queue head.
  always @(negedge clk) begin
    if (!rst && rsp_val && rsp_rdy) begin
      n_compared++;
      if (exp_q.size() == 0) begin
        n_mismatched++;
        $display("FAIL rsp_unexpected: got wr=%0b err=%0b data=%h, expected none",
                 rsp_is_wr, rsp_err, rsp_data);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        if ({rsp_is_wr, rsp_err, rsp_data} !== e) begin
          n_mismatched++;
          $display("FAIL rsp_fields: got wr=%0b err=%0b data=%h, expected wr=%0b err=%0b data=%h",
                   rsp_is_wr, rsp_err, rsp_data, e[33], e[32], e[31:0]);
        end
      end
    end
  end

  task automatic issue(input logic wen, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata, input logic [33:0] exp);
    int waited = 0;
    @(negedge clk);
    req_val = 1'b1; req_wen = wen; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata;
    while (!req_rdy && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!req_rdy) begin
      n_compared++; n_mismatched++;
      $display("FAIL issue_timeout: req_rdy=%0b after %0d cycles, expected 1", req_rdy, waited);
      req_val = 1'b0;
    end else begin
      exp_q.push_back(exp);
      @(posedge clk);
      #1 req_val = 1'b0;
    end
  endtask

  task automatic drain();
    int cyc = 0;
    rsp_rdy = 1'b1;
    while (exp_q.size() != 0 && cyc < 200) begin
      @(posedge clk);
      cyc++;
    end
    n_compared++;
    if (exp_q.size() != 0) begin
      n_mismatched++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  // Independent reference: walks the access byte by byte.
  task automatic model_op(input logic wen, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wdata, output logic [33:0] exp);
    int nbytes;
    int lane;
    logic [31:0] val;
    nbytes = 1 << size;
    val = '0;
    for (int b = 0; b < nbytes; b++) begin
      lane = int'(addr[1:0]) + b;
      if (wen) model_mem[addr[11:2]][lane*8 +: 8] = wdata[b*8 +: 8];
      else     val[b*8 +: 8] = model_mem[addr[11:2]][lane*8 +: 8];
    end
    if (!wen && !uns && nbytes == 1) val = {{24{val[7]}}, val[7:0]};
    if (!wen && !uns && nbytes == 2) val = {{16{val[15]}}, val[15:0]};
    exp = {wen, 1'b0, (wen ? 32'd0 : val)};
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_compared++;
    if ({req_rdy, rsp_val, rsp_is_wr, rsp_err} !== 4'b0000 || rsp_data !== 32'd0) begin
      n_mismatched++;
      $display("FAIL reset_outputs: got rdy=%0b val=%0b wr=%0b err=%0b data=%h, expected all 0",
               req_rdy, rsp_val, rsp_is_wr, rsp_err, rsp_data);
    end
    rst = 1'b0;
    #1;
    n_compared++;
    if (req_rdy !== 1'b1) begin
      n_mismatched++;
      $display("FAIL reset_release_rdy: got %0b, expected 1", req_rdy);
    end
  endtask

  task automatic test_store_load();
    int cyc = 0;
    issue(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, {1'b1, 1'b0, 32'd0});
    drain();
    issue(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, {1'b0, 1'b0, 32'hDEADBEEF});
    while (!rsp_val && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_compared++;
    if (cyc != LATENCY) begin
      n_mismatched++;
      $display("FAIL load_latency: got %0d cycles, expected %0d", cyc, LATENCY);
    end
    drain();
  endtask

  task automatic test_extension();
    issue(1'b0, 32'h13, 2'd0, 1'b0, 32'h0, {2'b00, 32'hFFFFFFDE});
    issue(1'b0, 32'h13, 2'd0, 1'b1, 32'h0, {2'b00, 32'h000000DE});
    issue(1'b0, 32'h10, 2'd1, 1'b0, 32'h0, {2'b00, 32'hFFFFBEEF});
    issue(1'b0, 32'h12, 2'd1, 1'b1, 32'h0, {2'b00, 32'h0000DEAD});
    drain();
  endtask

  task automatic test_partial_store();
    issue(1'b1, 32'h11, 2'd0, 1'b0, 32'h12345677, {2'b10, 32'd0});
    issue(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, {2'b00, 32'hDEAD77EF});
    drain();
  endtask

  task automatic test_errors();
    issue(1'b0, 32'h12, 2'd2, 1'b0, 32'h0, {2'b01, 32'd0});
    issue(1'b1, 32'h11, 2'd1, 1'b0, 32'hFFFF, {2'b11, 32'd0});
    issue(1'b1, 32'h10, 2'd3, 1'b0, 32'h0, {2'b11, 32'd0});
    issue(1'b0, 32'h1000, 2'd2, 1'b0, 32'h0, {2'b01, 32'd0});
    issue(1'b1, 32'h1010, 2'd2, 1'b0, 32'h0, {2'b11, 32'd0});
    issue(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, {2'b00, 32'hDEAD77EF});
    drain();
  endtask

  task automatic test_backpressure();
    logic [31:0] bytes_exp [4];
    int acc = 0;
    bytes_exp[0] = 32'hEF; bytes_exp[1] = 32'h77; bytes_exp[2] = 32'hAD; bytes_exp[3] = 32'hDE;
    @(posedge clk); #1 rsp_rdy = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      req_val = 1'b1; req_wen = 1'b0; req_size = 2'd0; req_unsigned = 1'b1;
      req_addr = 32'h10 + 32'(acc % 4);
      if (req_rdy) begin
        exp_q.push_back({2'b00, bytes_exp[acc % 4]});
        acc++;
      end
    end
    @(posedge clk); #1;
    req_val = 1'b0;
    n_compared++;
    if (acc != RSP_DEPTH || req_rdy !== 1'b0) begin
      n_mismatched++;
      $display("FAIL bp_credit: got accepted=%0d rdy=%0b, expected accepted=%0d rdy=0",
               acc, req_rdy, RSP_DEPTH);
    end
    rsp_rdy = 1'b1;
    @(posedge clk); #1;
    n_compared++;
    if (req_rdy !== 1'b1) begin
      n_mismatched++;
      $display("FAIL bp_rdy_return: got %0b one cycle after first pop, expected 1", req_rdy);
    end
    drain();
  endtask

  task automatic test_reset_midstream();
    rsp_rdy = 1'b0;
    issue(1'b1, 32'h20, 2'd2, 1'b0, 32'hCAFEF00D, {2'b10, 32'd0});
    issue(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, {2'b00, 32'hDEAD77EF});
    issue(1'b0, 32'h20, 2'd2, 1'b0, 32'h0, {2'b00, 32'hCAFEF00D});
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    n_compared++;
    if (rsp_val !== 1'b0 || req_rdy !== 1'b0) begin
      n_mismatched++;
      $display("FAIL reset_mid: got val=%0b rdy=%0b during reset, expected 0 0", rsp_val, req_rdy);
    end
    @(negedge clk);
    rst = 1'b0;
    rsp_rdy = 1'b1;
    #1;
    n_compared++;
    if (req_rdy !== 1'b1) begin
      n_mismatched++;
      $display("FAIL reset_mid_rdy: got %0b after reset, expected 1", req_rdy);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_compared++;
      if (rsp_val !== 1'b0) begin
        n_mismatched++;
        $display("FAIL reset_mid_stale: got rsp_val=%0b at cycle %0d, expected 0", rsp_val, c);
      end
    end
    issue(1'b0, 32'h20, 2'd2, 1'b0, 32'h0, {2'b00, 32'hCAFEF00D});
    drain();
  endtask

  task automatic test_random();
    logic [33:0] e;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  sz;
    logic        w;
    logic        u;
    for (int i = 0; i < 16; i++) begin
      d = $urandom();
      a = 32'h100 + 32'(i * 4);
      model_op(1'b1, a, 2'd2, 1'b0, d, e);
      issue(1'b1, a, 2'd2, 1'b0, d, e);
    end
    for (int i = 0; i < 60; i++) begin
      w  = 1'($urandom_range(0, 1));
      u  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 2));
      d  = $urandom();
      a  = 32'h100 + 32'($urandom_range(0, 15) * 4);
      if (sz == 2'd0) a = a + 32'($urandom_range(0, 3));
      if (sz == 2'd1) a = a + 32'($urandom_range(0, 1) * 2);
      model_op(w, a, sz, u, d, e);
      issue(w, a, sz, u, d, e);
    end
    drain();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    test_reset();
    test_store_load();
    test_extension();
    test_partial_store();
    test_errors();
    test_backpressure();
    test_reset_midstream();
    test_random();
    n_compared++;
    if (exp_q.size() != 0) begin
      n_mismatched++;
      $display("FAIL final_queue: got %0d outstanding, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
